obi_rr_mux: RTL and testbench
=============================

OBI_RR_MUX -- requirements
Module: obi_rr_mux

Interface
REQ-001 SHALL have parameter ObiCfg, default obi_pkg::ObiDefaultConfig, OBI configuration; only UseRReady is used.
REQ-002 SHALL have parameters obi_req_t and obi_rsp_t, default logic, request/response structs with fields req, a, rready and gnt, rvalid, r.
REQ-003 SHALL have parameter NumSbrPorts, default 2, number of requesters sharing the manager port; legal range 2..16.
REQ-004 SHALL have parameter MaxTrans, default 2, maximum outstanding granted-but-unanswered transactions; legal range 1..16.
REQ-005 SHALL have port clk_i input 1, single clock, all state on rising edge.
REQ-006 SHALL have port rst_i input 1, reset, synchronous and active-high.
REQ-007 SHALL have port sbr_ports_req_i input [NumSbrPorts] x obi_req_t, requester requests.
REQ-008 SHALL have port sbr_ports_rsp_o output [NumSbrPorts] x obi_rsp_t, requester responses.
REQ-009 SHALL have port mgr_port_req_o output obi_req_t, shared manager request.
REQ-010 SHALL have port mgr_port_rsp_i input obi_rsp_t, shared manager response.

Function
REQ-011 SHALL forward exactly one selected requester's req and a to mgr_port_req_o; mgr_port_req_o.req=0 when no requester is eligible.
REQ-012 SHALL select round-robin: search starts at index last_grant+1 modulo NumSbrPorts, first port with req=1 wins.
REQ-013 SHALL update last_grant only on an A handshake (mgr req & gnt).
REQ-014 SHALL hold the selection on the same port while mgr_port_req_o.req=1 and gnt=0 (lock state), so forwarded a is stable until gnt.
REQ-015 SHALL drive sbr_ports_rsp_o[i].gnt = mgr_port_rsp_i.gnt only for the selected port; 0 for all others.
REQ-016 SHALL push the granted port index into an in-order route FIFO of depth MaxTrans on each A handshake.
REQ-017 SHALL, when the route FIFO is full, force mgr_port_req_o.req=0 and all gnt=0, even if a response pops in the same cycle (no combinational rvalid-to-gnt path).
REQ-018 SHALL route mgr_port_rsp_i.rvalid and r to the port at FIFO head; all other ports see rvalid=0, r unchanged copy permitted.
REQ-019 SHALL pop the FIFO on an R handshake: rvalid & rready-of-head when ObiCfg.UseRReady, else rvalid alone.
REQ-020 SHALL drive mgr_port_req_o.rready = rready of head port when UseRReady and FIFO non-empty, 0 when empty; tie 1 when not UseRReady.
REQ-021 SHALL allow push and pop in the same cycle; occupancy then unchanged.
REQ-022 SHALL ignore rvalid while the FIFO is empty (no sbr rvalid asserted, no state change).
REQ-023 SHALL add zero cycles of latency on both A and R paths (purely combinational forwarding, state only for arbitration and routing).
REQ-024 SHALL allow a grant to the port whose response is returning in the same cycle.

Reset
REQ-025 SHALL, while rst_i=1, set last_grant to NumSbrPorts-1 (so port 0 has first priority), clear lock, empty FIFO.
REQ-026 SHALL hold mgr_port_req_o.req=0 and all sbr gnt/rvalid=0 during reset.
REQ-027 SHALL discard outstanding route entries on reset mid-operation; subsequent stray rvalid handled per REQ-022.

Verification
REQ-028 SHALL cover, NumSbrPorts=4, MaxTrans=2: ports 0..3 all req continuously, gnt=1 -> grants in order 0,1,2,3,0.
REQ-029 SHALL cover: port 2 req, gnt=0 for 3 cycles, port 0 raises req in cycle 2 -> selection stays on 2 until gnt, then 0 next.
REQ-030 SHALL cover: two grants (ports 1, 3) with no rvalid -> FIFO full, port 0 req sees gnt=0; rvalid then routes to 1, then 3, then port 0 granted.
REQ-031 SHALL cover UseRReady=1: rvalid=1 with head port rready=0 for 2 cycles -> mgr rready=0, FIFO not popped, response delivered on third cycle.
REQ-032 SHALL cover: same-cycle grant and rvalid with FIFO at 1 entry -> occupancy stays 1, new entry routed next.
REQ-033 SHALL cover: rst_i asserted with 2 outstanding -> FIFO empty, next grant goes to port 0, stray rvalid produces no sbr rvalid.

Source files
------------

// File: rtl/obi_rr_mux.sv
// OBI round-robin multiplexer: N requesters onto one manager port.
// Zero-latency A/R forwarding, in-order response routing FIFO.

package obi_pkg;

  typedef struct packed {
    logic        UseRReady;
    int unsigned AddrWidth;
    int unsigned DataWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    UseRReady: 1'b0,
    AddrWidth: 32,
    DataWidth: 32
  };

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_a_chan_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module obi_rr_mux #(
  parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
  parameter type obi_req_t = obi_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter int unsigned NumSbrPorts = 2,
  parameter int unsigned MaxTrans = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t sbr_ports_req_i [NumSbrPorts],
  output obi_rsp_t sbr_ports_rsp_o [NumSbrPorts],
  output obi_req_t mgr_port_req_o,
  input  obi_rsp_t mgr_port_rsp_i
);

  localparam int unsigned IdxW = $clog2(NumSbrPorts);
  localparam int unsigned PtrW =
    (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic {
    StArb,
    StLock
  } state_e;

  // Arbitration state
  state_e state_q, state_d;
  idx_t   last_q, last_d;
  idx_t   lock_idx_q, lock_idx_d;

  // Route FIFO state
  idx_t   fifo_q [MaxTrans];
  ptr_t   wptr_q, wptr_d;
  ptr_t   rptr_q, rptr_d;
  cnt_t   cnt_q, cnt_d;

  // Combinational datapath
  idx_t   rr_idx;
  idx_t   cand;
  logic   rr_found;
  idx_t   sel_idx;
  logic   sel_req;
  logic   fifo_full;
  logic   fifo_empty;
  logic   mgr_req;
  logic   a_hs;
  idx_t   head;
  logic   head_rready;
  logic   r_ok;
  logic   rsp_valid;
  logic   r_hs;

  // Round-robin search starting one past the last granted port
  always_comb begin
    rr_idx   = last_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= NumSbrPorts; k++) begin
      cand = idx_t'((32'(last_q) + k) % NumSbrPorts);
      if (!rr_found && sbr_ports_req_i[cand].req) begin
        rr_idx   = cand;
        rr_found = 1'b1;
      end
    end
  end

  // Selection: hold the locked port until its request is granted
  always_comb begin
    sel_idx    = (state_q == StLock) ? lock_idx_q : rr_idx;
    sel_req    = sbr_ports_req_i[sel_idx].req;
    fifo_full  = (cnt_q == cnt_t'(MaxTrans));
    fifo_empty = (cnt_q == '0);
    mgr_req    = sel_req & ~fifo_full & ~rst_i;
    a_hs       = mgr_req & mgr_port_rsp_i.gnt;
  end

  // Response side: the FIFO head owns the R channel
  always_comb begin
    head        = fifo_q[rptr_q];
    head_rready = sbr_ports_req_i[head].rready;
    r_ok        = ObiCfg.UseRReady ? head_rready : 1'b1;
    rsp_valid   = mgr_port_rsp_i.rvalid & ~fifo_empty & ~rst_i;
    r_hs        = rsp_valid & r_ok;
  end

  // Manager request: forward the selected port, override req/rready
  always_comb begin
    mgr_port_req_o     = sbr_ports_req_i[sel_idx];
    mgr_port_req_o.req = mgr_req;
    if (ObiCfg.UseRReady) begin
      mgr_port_req_o.rready = ~fifo_empty & head_rready;
    end else begin
      mgr_port_req_o.rready = 1'b1;
    end
  end

  // Requester responses: gnt to the selected port, rvalid to the head
  always_comb begin
    for (int unsigned i = 0; i < NumSbrPorts; i++) begin
      sbr_ports_rsp_o[i]        = mgr_port_rsp_i;
      sbr_ports_rsp_o[i].gnt    = a_hs & (sel_idx == idx_t'(i));
      sbr_ports_rsp_o[i].rvalid = rsp_valid & (head == idx_t'(i));
    end
  end

  // Next-state for arbitration and FIFO pointers
  always_comb begin
    state_d    = (mgr_req & ~mgr_port_rsp_i.gnt) ? StLock : StArb;
    lock_idx_d = sel_idx;
    last_d     = a_hs ? sel_idx : last_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (a_hs) begin
      wptr_d = (wptr_q == ptr_t'(MaxTrans - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (r_hs) begin
      rptr_d = (rptr_q == ptr_t'(MaxTrans - 1)) ? '0 : rptr_q + 1'b1;
    end
    cnt_d = cnt_q + cnt_t'(a_hs) - cnt_t'(r_hs);
  end

  // Control registers; reset gives port 0 first priority
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StArb;
      last_q     <= idx_t'(NumSbrPorts - 1);
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_idx_q <= lock_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Route FIFO storage; entries are only valid below cnt_q
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < MaxTrans; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (a_hs) begin
      fifo_q[wptr_q] <= sel_idx;
    end
  end

`ifndef SYNTHESIS
  a_no_push_full : assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(a_hs && fifo_full)
  );

  a_no_pop_empty : assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(r_hs && fifo_empty)
  );

  a_sel_stable : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (mgr_req && !mgr_port_rsp_i.gnt) |=> (sel_idx == $past(sel_idx))
  );
`endif

endmodule

// File: tb/tb_obi_rr_mux.sv
// Testbench for obi_rr_mux: directed scenarios plus
// random traffic against a queue-based reference model.

module tb_obi_rr_mux;
  import obi_pkg::*;

  localparam int N  = 4;
  localparam int MT = 2;
  localparam obi_cfg_t Cfg = '{
    UseRReady: 1'b1,
    AddrWidth: 32,
    DataWidth: 32
  };

  logic     clk = 1'b0;
  logic     rst;
  obi_req_t sbr_req [N];
  obi_rsp_t sbr_rsp [N];
  obi_req_t mgr_req;
  obi_rsp_t mgr_rsp;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int       q[$];
  int       last;
  bit       lk;
  int       lk_port;
  bit       e_req;
  int       e_sel;
  logic [3:0] e_gnt;
  logic [3:0] e_rv;
  logic     e_rr;
  bit       hold [N];

  obi_rr_mux #(
    .ObiCfg      (Cfg),
    .obi_req_t   (obi_req_t),
    .obi_rsp_t   (obi_rsp_t),
    .NumSbrPorts (N),
    .MaxTrans    (MT)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .sbr_ports_req_i (sbr_req),
    .sbr_ports_rsp_o (sbr_rsp),
    .mgr_port_req_o  (mgr_req),
    .mgr_port_rsp_i  (mgr_rsp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] gvec();
    logic [3:0] v;
    for (int i = 0; i < N; i++) v[i] = sbr_rsp[i].gnt;
    return v;
  endfunction

  function automatic logic [3:0] rvec();
    logic [3:0] v;
    for (int i = 0; i < N; i++) v[i] = sbr_rsp[i].rvalid;
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    last = N - 1;
    lk   = 0;
    lk_port = 0;
    for (int i = 0; i < N; i++) hold[i] = 0;
  endtask

  // Expected outputs for the current inputs and model state
  task automatic model_eval();
    e_gnt = '0;
    e_rv  = '0;
    e_req = 0;
    e_rr  = 0;
    e_sel = -1;
    if (q.size() > 0) e_rr = sbr_req[q[0]].rready;
    if (!rst) begin
      if (lk) begin
        e_sel = lk_port;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int p;
          p = (last + k) % N;
          if (e_sel < 0 && sbr_req[p].req) e_sel = p;
        end
      end
      if (e_sel >= 0 && q.size() < MT && sbr_req[e_sel].req)
        e_req = 1;
      if (e_req && mgr_rsp.gnt) e_gnt[e_sel] = 1'b1;
      if (q.size() > 0 && mgr_rsp.rvalid) e_rv[q[0]] = 1'b1;
    end
  endtask

  // Advance the model across one rising edge
  task automatic model_update();
    if (rst) begin
      model_reset();
    end else begin
      if (q.size() > 0 && mgr_rsp.rvalid && sbr_req[q[0]].rready)
        void'(q.pop_front());
      if (e_req && mgr_rsp.gnt) begin
        q.push_back(e_sel);
        last = e_sel;
      end
      lk      = e_req && !mgr_rsp.gnt;
      lk_port = e_sel;
      for (int i = 0; i < N; i++)
        hold[i] = sbr_req[i].req && !e_gnt[i];
    end
  endtask

  // One cycle: compare outputs, optional directed vectors, clock
  task automatic step(input bit d,
                      input logic [3:0] dg,
                      input logic [3:0] dr);
    #1;
    model_eval();
    chk("mgr_req", 64'(mgr_req.req), 64'(e_req));
    if (e_req)
      chk("mgr_addr", 64'(mgr_req.a.addr),
          64'(sbr_req[e_sel].a.addr));
    chk("gnt_vec", 64'(gvec()), 64'(e_gnt));
    chk("rvalid_vec", 64'(rvec()), 64'(e_rv));
    chk("mgr_rready", 64'(mgr_req.rready), 64'(e_rr));
    if (e_rv != '0)
      chk("rdata", 64'(sbr_rsp[q[0]].r.rdata),
          64'(mgr_rsp.r.rdata));
    if (d) begin
      chk("dir_gnt", 64'(gvec()), 64'(dg));
      chk("dir_rvalid", 64'(rvec()), 64'(dr));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) begin
      sbr_req[i].req    = 1'b0;
      sbr_req[i].a      = '0;
      sbr_req[i].rready = 1'b1;
    end
    mgr_rsp = '0;
  endtask

  task automatic set_req(input int p, input bit v);
    sbr_req[p].req = v;
    if (v) begin
      sbr_req[p].a.addr  = $urandom;
      sbr_req[p].a.we    = 1'($urandom);
      sbr_req[p].a.wdata = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1, 4'b0000, 4'b0000);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();

    // Reset with every requester active: nothing granted
    for (int i = 0; i < N; i++) set_req(i, 1);
    mgr_rsp.gnt    = 1'b1;
    mgr_rsp.rvalid = 1'b1;
    step(1, 4'b0000, 4'b0000);
    chk("rst_mgr_req", 64'(mgr_req.req), 64'(0));

    // All ports requesting, gnt=1: grants 0,1,2,3,0
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mgr_rsp.r.rdata = $urandom;
      step(1, 4'(1 << (k % 4)),
           (k == 0) ? 4'b0000 : 4'(1 << ((k - 1) % 4)));
      for (int i = 0; i < N; i++) set_req(i, 1);
    end

    // Port 2 locked while gnt=0, port 0 arrives meanwhile
    idle();
    do_reset();
    set_req(2, 1);
    step(1, 4'b0000, 4'b0000);
    set_req(0, 1);
    step(1, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b0000);
    mgr_rsp.gnt = 1'b1;
    step(1, 4'b0100, 4'b0000);
    sbr_req[2].req = 1'b0;
    step(1, 4'b0001, 4'b0000);

    // FIFO full blocks port 0; responses drain 1 then 3
    idle();
    do_reset();
    set_req(1, 1);
    set_req(3, 1);
    mgr_rsp.gnt = 1'b1;
    step(1, 4'b0010, 4'b0000);
    sbr_req[1].req = 1'b0;
    step(1, 4'b1000, 4'b0000);
    sbr_req[3].req = 1'b0;
    set_req(0, 1);
    step(1, 4'b0000, 4'b0000);
    chk("full_mgr_req", 64'(mgr_req.req), 64'(0));
    mgr_rsp.rvalid  = 1'b1;
    mgr_rsp.r.rdata = 32'h1111_0001;
    step(1, 4'b0000, 4'b0010);
    mgr_rsp.r.rdata = 32'h3333_0003;
    step(1, 4'b0001, 4'b1000);
    sbr_req[0].req  = 1'b0;
    mgr_rsp.r.rdata = 32'h0000_0a0a;
    step(1, 4'b0000, 4'b0001);

    // Head port stalls rready for two cycles
    idle();
    do_reset();
    set_req(1, 1);
    mgr_rsp.gnt = 1'b1;
    step(1, 4'b0010, 4'b0000);
    sbr_req[1].req    = 1'b0;
    sbr_req[1].rready = 1'b0;
    mgr_rsp.gnt       = 1'b0;
    mgr_rsp.rvalid    = 1'b1;
    step(1, 4'b0000, 4'b0010);
    step(1, 4'b0000, 4'b0010);
    sbr_req[1].rready = 1'b1;
    step(1, 4'b0000, 4'b0010);
    step(1, 4'b0000, 4'b0000);

    // Reset with two outstanding, then stray rvalid
    idle();
    do_reset();
    set_req(2, 1);
    set_req(3, 1);
    mgr_rsp.gnt = 1'b1;
    step(1, 4'b0100, 4'b0000);
    sbr_req[2].req = 1'b0;
    step(1, 4'b1000, 4'b0000);
    sbr_req[3].req = 1'b0;
    mgr_rsp.rvalid = 1'b1;
    rst = 1'b1;
    step(1, 4'b0000, 4'b0000);
    rst = 1'b0;
    set_req(0, 1);
    set_req(1, 1);
    step(1, 4'b0001, 4'b0000);

    // Random OBI-compliant traffic
    idle();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) set_req(i, ($urandom_range(0, 2) != 0));
        sbr_req[i].rready = ($urandom_range(0, 3) != 0);
      end
      mgr_rsp.gnt     = ($urandom_range(0, 3) != 0);
      mgr_rsp.rvalid  = 1'($urandom);
      mgr_rsp.r.rdata = $urandom;
      mgr_rsp.r.err   = 1'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      step(0, 4'b0000, 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
